// File: rtl/simon_seq_game.sv
// rtl/simon_seq_game.sv - parametrised memory-sequence game controller
//
// Plays back a growing random key sequence on the LED bank and then waits
// for the player to echo it on the key pad.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   start   in   synchronous game (re)start, overrides every state
//   k       in   key inputs, active-high, lowest index wins
//   nl      out  key LEDs, active-high
//   nloss   out  loss LED
//   speaker out  square-wave tone
//   level   out  number of completed rounds
//   busy    out  high in every state except IDLE
module simon_seq_game #(
  parameter int NUM_KEYS  = 4,
  parameter int ADDR_W    = 5,
  parameter int TB_INIT   = 33,
  parameter int TB_DEC    = 1,
  parameter int TB_MIN    = 4,
  parameter int COUNT_KEY = 33,
  parameter int COUNT_FIN = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [NUM_KEYS-1:0] k,
  output logic [NUM_KEYS-1:0] nl,
  output logic                nloss,
  output logic                speaker,
  output logic [ADDR_W:0]     level,
  output logic                busy
);
  localparam int KW       = $clog2(NUM_KEYS);
  localparam int SIZE_MEM = 2 ** ADDR_W;
  localparam int LW       = ADDR_W + 1;
  localparam int TBW      = 6;
  localparam int CNT_MAX  = (TB_INIT > COUNT_KEY) ?
                            ((TB_INIT > COUNT_FIN) ? TB_INIT : COUNT_FIN) :
                            ((COUNT_KEY > COUNT_FIN) ? COUNT_KEY : COUNT_FIN);
  localparam int CW       = $clog2(CNT_MAX + 1);
  // Sound code: 0..NUM_KEYS-1 are keys, then the loss and win tones.
  localparam int SW       = KW + 1;
  localparam int TW       = $clog2(NUM_KEYS + 4);
  localparam logic [SW-1:0]       LOSS_SND = SW'(NUM_KEYS);
  localparam logic [SW-1:0]       WIN_SND  = SW'(NUM_KEYS + 1);
  localparam logic [NUM_KEYS-1:0] ONE_HOT0 = NUM_KEYS'(1);

  typedef enum logic [3:0] {
    IDLE, INIT, APPEND, S_ADDR, S_READ, S_ON, S_HOLD, S_OFF,
    K_ADDR, K_READ, K_WAIT, K_HOLD, K_OFF, LOSS_HOLD, LOSS, WIN
  } state_t;

  state_t              state_q;
  logic [NUM_KEYS-1:0] nl_q;
  logic                nloss_q, play_q, busy_q, phase_q, speaker_q;
  logic [SW-1:0]       sound_q;
  logic [CW-1:0]       count_q;
  logic [ADDR_W-1:0]   scan_q, max_q, address_q;
  logic [LW-1:0]       level_q;
  logic [TBW-1:0]      timebase_q;
  logic [KW-1:0]       num_q, data_out_q;
  logic [TW-1:0]       tone_cnt_q;
  logic [KW-1:0]       mem_q [SIZE_MEM];

  logic                key_hit_d;
  logic [KW-1:0]       key_idx_d;
  logic [TBW-1:0]      tb_next_d;
  logic [TW-1:0]       half_d;

  // Priority encoder: scanning downwards lets the lowest pressed key win.
  always_comb begin
    key_hit_d = 1'b0;
    key_idx_d = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (k[i]) begin
        key_hit_d = 1'b1;
        key_idx_d = KW'(i);
      end
    end
  end

  always_comb begin
    if (int'(timebase_q) >= TB_MIN + TB_DEC) tb_next_d = timebase_q - TBW'(TB_DEC);
    else                                     tb_next_d = TBW'(TB_MIN);
  end

  always_comb begin
    if (sound_q == LOSS_SND)     half_d = TW'(2);
    else if (sound_q == WIN_SND) half_d = TW'(NUM_KEYS + 3);
    else                         half_d = TW'(sound_q) + TW'(3);
  end

  // Sequence memory: contents survive reset, reads land one cycle later.
  always_ff @(posedge clock) begin
    if (state_q == APPEND) mem_q[max_q] <= num_q;
    data_out_q <= mem_q[address_q];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      nl_q       <= '0;
      nloss_q    <= 1'b0;
      play_q     <= 1'b0;
      busy_q     <= 1'b0;
      phase_q    <= 1'b0;
      sound_q    <= '0;
      count_q    <= '0;
      scan_q     <= '0;
      max_q      <= '0;
      address_q  <= '0;
      level_q    <= '0;
      timebase_q <= TBW'(TB_INIT);
      num_q      <= '0;
    end else begin
      num_q <= (num_q == KW'(NUM_KEYS - 1)) ? '0 : num_q + KW'(1);
      if (start) begin
        // Clear the visible game state on the start edge itself.
        state_q    <= INIT;
        busy_q     <= 1'b1;
        nl_q       <= '0;
        nloss_q    <= 1'b0;
        play_q     <= 1'b0;
        max_q      <= '0;
        scan_q     <= '0;
        level_q    <= '0;
        timebase_q <= TBW'(TB_INIT);
      end else begin
        case (state_q)
          IDLE: state_q <= IDLE;
          INIT: begin
            nl_q       <= '0;
            nloss_q    <= 1'b0;
            play_q     <= 1'b0;
            max_q      <= '0;
            level_q    <= '0;
            timebase_q <= TBW'(TB_INIT);
            state_q    <= APPEND;
          end
          APPEND: begin
            scan_q  <= '0;
            state_q <= S_ADDR;
          end
          S_ADDR: begin
            address_q <= scan_q;
            state_q   <= S_READ;
          end
          S_READ: state_q <= S_ON;
          S_ON: begin
            nl_q    <= ONE_HOT0 << data_out_q;
            play_q  <= 1'b1;
            sound_q <= {1'b0, data_out_q};
            count_q <= CW'(timebase_q);
            state_q <= S_HOLD;
          end
          S_HOLD, K_HOLD: begin
            if (count_q == '0) begin
              nl_q    <= '0;
              play_q  <= 1'b0;
              count_q <= CW'(timebase_q);
              state_q <= (state_q == S_HOLD) ? S_OFF : K_OFF;
            end else count_q <= count_q - CW'(1);
          end
          S_OFF: begin
            if (count_q == '0) begin
              if (scan_q != max_q) begin
                scan_q  <= scan_q + ADDR_W'(1);
                state_q <= S_ADDR;
              end else begin
                scan_q  <= '0;
                state_q <= K_ADDR;
              end
            end else count_q <= count_q - CW'(1);
          end
          K_ADDR: begin
            address_q <= scan_q;
            count_q   <= CW'(COUNT_KEY);
            state_q   <= K_READ;
          end
          K_READ: state_q <= K_WAIT;
          K_WAIT: begin
            if (count_q == '0) begin
              state_q   <= LOSS;
              nloss_q   <= 1'b1;
              nl_q      <= '0;
              play_q    <= 1'b0;
              address_q <= max_q;
              count_q   <= CW'(COUNT_FIN - 1);
              phase_q   <= 1'b0;
            end else if (key_hit_d) begin
              nl_q    <= ONE_HOT0 << key_idx_d;
              play_q  <= 1'b1;
              sound_q <= {1'b0, key_idx_d};
              count_q <= CW'(timebase_q);
              if (key_idx_d == data_out_q) state_q <= K_HOLD;
              else begin
                nloss_q <= 1'b1;
                state_q <= LOSS_HOLD;
              end
            end else count_q <= count_q - CW'(1);
          end
          K_OFF: begin
            if (count_q == '0) begin
              if (scan_q != max_q) begin
                scan_q  <= scan_q + ADDR_W'(1);
                state_q <= K_ADDR;
              end else if (max_q != ADDR_W'(SIZE_MEM - 1)) begin
                max_q      <= max_q + ADDR_W'(1);
                level_q    <= level_q + LW'(1);
                timebase_q <= tb_next_d;
                state_q    <= APPEND;
              end else begin
                level_q <= level_q + LW'(1);
                nl_q    <= '1;
                play_q  <= 1'b0;
                count_q <= CW'(COUNT_FIN - 1);
                phase_q <= 1'b0;
                state_q <= WIN;
              end
            end else count_q <= count_q - CW'(1);
          end
          LOSS_HOLD: begin
            if (count_q == '0) begin
              nl_q      <= '0;
              play_q    <= 1'b0;
              address_q <= max_q;
              count_q   <= CW'(COUNT_FIN - 1);
              phase_q   <= 1'b0;
              state_q   <= LOSS;
            end else count_q <= count_q - CW'(1);
          end
          LOSS: begin
            // The loss blink shows the last element of the failed sequence.
            nloss_q <= 1'b1;
            if (count_q == '0) begin
              phase_q <= ~phase_q;
              count_q <= CW'(COUNT_FIN - 1);
              if (!phase_q) begin
                nl_q    <= ONE_HOT0 << data_out_q;
                sound_q <= LOSS_SND;
                play_q  <= 1'b1;
              end else begin
                nl_q   <= '0;
                play_q <= 1'b0;
              end
            end else count_q <= count_q - CW'(1);
          end
          WIN: begin
            if (count_q == '0) begin
              phase_q <= ~phase_q;
              count_q <= CW'(COUNT_FIN - 1);
              if (!phase_q) begin
                nl_q    <= '0;
                sound_q <= WIN_SND;
                play_q  <= 1'b1;
              end else begin
                nl_q   <= '1;
                play_q <= 1'b0;
              end
            end else count_q <= count_q - CW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Tone generator: speaker toggles every half_d cycles while play_q is set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      speaker_q  <= 1'b0;
      tone_cnt_q <= '0;
    end else if (!play_q) begin
      speaker_q  <= 1'b0;
      tone_cnt_q <= '0;
    end else if (tone_cnt_q + TW'(1) >= half_d) begin
      speaker_q  <= ~speaker_q;
      tone_cnt_q <= '0;
    end else begin
      tone_cnt_q <= tone_cnt_q + TW'(1);
    end
  end

  assign nl      = nl_q;
  assign nloss   = nloss_q;
  assign speaker = speaker_q;
  assign level   = level_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_simon_seq_game.sv
// tb/tb_simon_seq_game.sv - self-checking bench for simon_seq_game
module tb_simon_seq_game;
  localparam int NK     = 4;
  localparam int AW     = 2;
  localparam int TBI    = 33;
  localparam int TBM    = 30;
  localparam int CKEY   = 33;
  localparam int CFIN   = 8;
  localparam int ROUNDS = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [NK-1:0] k = '0;
  logic [NK-1:0] nl;
  logic          nloss, speaker, busy;
  logic [AW:0]   level;

  simon_seq_game #(
    .NUM_KEYS(NK), .ADDR_W(AW), .TB_INIT(TBI), .TB_DEC(1), .TB_MIN(TBM),
    .COUNT_KEY(CKEY), .COUNT_FIN(CFIN)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .k(k), .nl(nl),
    .nloss(nloss), .speaker(speaker), .level(level), .busy(busy)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int seq[$];
  int tb_m;
  int lvl_m;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  function automatic int onehot_idx(input logic [NK-1:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < NK; i++) if (v[i]) begin cnt++; idx = i; end
    return (cnt == 1) ? idx : -1;
  endfunction

  task automatic wait_lit(input string tag, input int gap, output int idx);
    int n = 0;
    while (nl == '0 && n < 400) begin tick(); n++; end
    check_eq({tag, "_gap"}, n, gap);
    idx = onehot_idx(nl);
    check_eq({tag, "_onehot"}, (idx >= 0) ? 1 : 0, 1);
    if (idx < 0) idx = 0;
  endtask

  // Length of the current constant-nl run and the offset of the first speaker high.
  task automatic run_nl(input bit noise, output int len, output logic [NK-1:0] val,
                        output int tog);
    val = nl;
    len = 0;
    tog = -1;
    while (nl == val && len < 400) begin
      if (noise) k = NK'($urandom);
      tick();
      len++;
      if (tog < 0 && nl == val && speaker) tog = len;
    end
    k = '0;
  endtask

  task automatic new_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("start_nl", nl, 0);
    check_eq("start_level", level, 0);
    check_eq("start_busy", busy, 1);
    seq.delete();
    lvl_m = 0;
    tb_m  = TBI;
  endtask

  task automatic display_round(input int first_gap);
    int idx, len, tog;
    logic [NK-1:0] v;
    for (int e = 0; e <= lvl_m; e++) begin
      wait_lit("disp", (e == 0) ? first_gap : tb_m + 4, idx);
      if (e < seq.size()) check_eq("disp_replay", idx, seq[e]);
      else seq.push_back(idx);
      run_nl(1'b1, len, v, tog);
      check_eq("disp_hold", len, tb_m + 1);
      check_eq("disp_tone", tog, idx + 3);
    end
  endtask

  // Press key (plus random higher keys) d cycles into the key window.
  task automatic press(input int key, input int d);
    repeat (tb_m + 3 + d) tick();
    k = NK'(1 << key) | (NK'($urandom) & ~NK'((2 << key) - 1));
    tick();
    k = '0;
  endtask

  task automatic echo_round(input int wrong_at);
    int len, tog, key;
    logic [NK-1:0] v;
    for (int e = 0; e <= lvl_m; e++) begin
      if (e == wrong_at) begin
        key = (seq[e] + 1 + int'($urandom_range(0, NK - 2))) % NK;
        press(key, $urandom_range(0, 20));
        check_eq("wrong_led", nl, 1 << key);
        check_eq("wrong_nloss", nloss, 1);
        run_nl(1'b1, len, v, tog);
        check_eq("wrong_hold", len, tb_m + 1);
        check_eq("wrong_tone", tog, key + 3);
        return;
      end
      press(seq[e], (e == 0) ? CKEY - 1 : $urandom_range(0, 20));
      check_eq("echo_led", nl, 1 << seq[e]);
      check_eq("echo_nloss", nloss, 0);
      run_nl(1'b1, len, v, tog);
      check_eq("echo_hold", len, tb_m + 1);
      check_eq("echo_tone", tog, seq[e] + 3);
    end
    repeat (tb_m) tick();
    check_eq("level_before", level, lvl_m);
    tick();
    lvl_m++;
    check_eq("level_after", level, lvl_m);
    if (lvl_m < ROUNDS) tb_m = (tb_m - 1 < TBM) ? TBM : tb_m - 1;
  endtask

  task automatic loss_blink(input int periods);
    int len, tog;
    logic [NK-1:0] v;
    for (int p = 0; p < periods; p++) begin
      run_nl(1'b1, len, v, tog);
      check_eq("loss_off_len", len, CFIN);
      check_eq("loss_off_nl", v, 0);
      check_eq("loss_nloss", nloss, 1);
      run_nl(1'b1, len, v, tog);
      check_eq("loss_on_len", len, CFIN);
      check_eq("loss_on_nl", v, 1 << seq[seq.size() - 1]);
      check_eq("loss_tone", tog, 2);
    end
  endtask

  task automatic win_blink(input int periods);
    int len, tog;
    logic [NK-1:0] v;
    for (int p = 0; p < periods; p++) begin
      run_nl(1'b1, len, v, tog);
      check_eq("win_a_len", len, CFIN);
      check_eq("win_a_nl", v, (1 << NK) - 1);
      run_nl(1'b1, len, v, tog);
      check_eq("win_b_len", len, CFIN);
      check_eq("win_b_nl", v, 0);
      check_eq("win_tone", tog, NK + 3);
      check_eq("win_level", level, ROUNDS);
    end
  endtask

  initial begin
    int idx, nz, n;
    // Reset behaviour, then idle with start low.
    repeat (10) begin
      k = NK'($urandom);
      start = 1'($urandom);
      tick();
    end
    check_eq("rst_nl", nl, 0);
    check_eq("rst_nloss", nloss, 0);
    check_eq("rst_speaker", speaker, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_busy", busy, 0);
    start = 1'b0;
    reset = 1'b1;
    nz = 0;
    repeat (100) begin
      k = NK'($urandom);
      tick();
      if (nl != 0 || nloss || speaker || level != 0 || busy) nz++;
    end
    k = '0;
    check_eq("idle_stay", nz, 0);

    // Game 1: two correct rounds, restart during round 3, then a wrong key.
    new_game();
    display_round(5);
    echo_round(-1);
    check_eq("tb_after_r1", tb_m, 32);
    display_round(4);
    echo_round(-1);
    wait_lit("r3", 4, idx);
    check_eq("r3_first", idx, seq[0]);
    repeat (3) tick();
    new_game();
    display_round(5);
    echo_round(-1);
    display_round(4);
    echo_round(1);
    loss_blink(2);

    // Game 2: key window timeout in round 1.
    new_game();
    display_round(5);
    repeat (tb_m + 3 + CKEY) tick();
    check_eq("timeout_pre", nloss, 0);
    tick();
    check_eq("timeout_nloss", nloss, 1);
    check_eq("timeout_level", level, 0);
    loss_blink(1);

    // Game 3: full win.
    new_game();
    display_round(5);
    echo_round(-1);
    for (int r = 1; r < ROUNDS; r++) begin
      display_round(4);
      echo_round(-1);
    end
    check_eq("win_tb_floor", tb_m, TBM);
    win_blink(2);

    // Asynchronous reset while a tone is sounding.
    new_game();
    wait_lit("art", 5, idx);
    n = 0;
    while (!speaker && n < 20) begin tick(); n++; end
    check_eq("art_tone_seen", speaker, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("art_speaker", speaker, 0);
    check_eq("art_nl", nl, 0);
    check_eq("art_busy", busy, 0);
    check_eq("art_level", level, 0);
    tick();
    reset = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
